// File: rtl/sync_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl_pkg
//
// Constants and helpers shared by the single-clock FIFO controllers.
//   fifo_depth(addr_size) : number of memory words addressed by the FIFO
//   ptr_width(addr_size)  : width of a wrap-tagged pointer (address + tag bit)
//   fifo_status_t         : bundle of the four occupancy flags
// ---------------------------------------------------------------------------
package sync_fifo_ctrl_pkg;

  localparam int default_addr_size  = 4;
  localparam int default_word_width = 8;

  // Number of words in a FIFO with the given address width.
  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  // Pointer width: one extra MSB distinguishes "full" from "empty" when the
  // address bits of the read and write pointers coincide.
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage : sync_fifo_ctrl_pkg

// File: rtl/sync_fifo_ctrl_fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
//
// Binary pointer with wrap tag. The low bits address the memory, the MSB
// toggles each time the address wraps. Incrementing past the all-ones value
// rolls to zero naturally.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, pointer returns to 0
//   inc    in   advance the pointer by one at the next rising edge
//   ptr    out  current pointer value (width bits, MSB = wrap tag)
// ---------------------------------------------------------------------------
module fifo_ptr #(
  parameter int width = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [width-1:0] ptr
);

  localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + one;
    end
  end

  assign ptr = ptr_q;

endmodule : fifo_ptr

// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO controller for an external register-file memory with one
// synchronous write port and one asynchronous read port. Converts push/pop
// requests into memory write-enable and addresses, keeps wrap-tagged
// pointers, derives occupancy and status flags, and registers pop data.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push request and data
//   rd_en             pop request
//   clr_err           clears the sticky overflow/underflow flags
//   mem_we            memory write enable (combinational)
//   mem_addr_w        memory write address (write pointer low bits)
//   mem_data_w        memory write data (wr_data passed straight through)
//   mem_addr_r        memory read address (read pointer low bits)
//   mem_data_r        memory asynchronous read data
//   rd_data, rd_valid registered pop data and its one-cycle valid pulse
//   full, empty, almost_full, almost_empty  occupancy flags
//   count             occupancy, 0 .. 2**addr_size
//   overflow, underflow  sticky error flags
//
// Request semantics: wr_en and rd_en are requests, and full / empty act as
// the inverted ready of each side. A request is accepted only when it is
// raised in a cycle where its ready holds (push while !full, pop while
// !empty), judged on the flags of that same cycle. A request made while not
// ready is dropped and recorded in the matching sticky error flag; the other
// side's request is still judged on its own.
// ---------------------------------------------------------------------------
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int addr_size  = default_addr_size,
  parameter int word_width = default_word_width,
  parameter int af_level   = (1 << addr_size) - 2,
  parameter int ae_level   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [word_width-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic                  mem_we,
  output logic [addr_size-1:0]  mem_addr_w,
  output logic [word_width-1:0] mem_data_w,
  output logic [addr_size-1:0]  mem_addr_r,
  input  logic [word_width-1:0] mem_data_r,
  output logic [word_width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_size:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int pw = ptr_width(addr_size);

  // Thresholds resized once to the count width so the comparisons below
  // are between equal-width unsigned values.
  localparam logic [pw-1:0] af_thresh = pw'(af_level);
  localparam logic [pw-1:0] ae_thresh = pw'(ae_level);

  logic [pw-1:0]         wr_ptr;
  logic [pw-1:0]         rd_ptr;
  logic [pw-1:0]         occupancy;
  fifo_status_t          status;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  push_blocked;
  logic                  pop_blocked;
  logic [word_width-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;

  // -------------------------------------------------------------------------
  // Pointers
  // -------------------------------------------------------------------------
  fifo_ptr #(.width(pw)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.width(pw)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  // -------------------------------------------------------------------------
  // Occupancy and flags, derived purely from the registered pointers, so
  // they change the cycle after an accepted operation.
  // -------------------------------------------------------------------------
  // Modulo subtraction handles the wrap tag: the result is always 0..depth.
  assign occupancy = wr_ptr - rd_ptr;

  always_comb begin
    status              = '0;
    status.empty        = (wr_ptr == rd_ptr);
    // Same address, opposite wrap tag: writer is exactly one lap ahead.
    status.full         = (wr_ptr[addr_size-1:0] == rd_ptr[addr_size-1:0]) &&
                          (wr_ptr[addr_size] != rd_ptr[addr_size]);
    status.almost_full  = (occupancy >= af_thresh);
    status.almost_empty = (occupancy <= ae_thresh);
  end

  // -------------------------------------------------------------------------
  // Request acceptance
  // -------------------------------------------------------------------------
  always_comb begin
    push_ok      = wr_en && !status.full;
    pop_ok       = rd_en && !status.empty;
    push_blocked = wr_en && status.full;
    pop_blocked  = rd_en && status.empty;
  end

  // -------------------------------------------------------------------------
  // Read data register: captures the asynchronous memory output on a pop,
  // holds its value otherwise.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_ok;
      if (pop_ok) begin
        rd_data_q <= mem_data_r;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags. A new error in the same cycle as clr_err wins, so
  // the set term is checked before the clear term.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_blocked) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end

      if (pop_blocked) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_we       = push_ok;
  assign mem_addr_w   = wr_ptr[addr_size-1:0];
  assign mem_data_w   = wr_data;
  assign mem_addr_r   = rd_ptr[addr_size-1:0];

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign count        = occupancy;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule : sync_fifo_ctrl

// File: tb/tb_sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_ctrl
//
// Self-checking bench for sync_fifo_ctrl (addr_size 4, word_width 8). Holds
// the external register-file memory, a hand-built vector table for the fill /
// overflow / drain / underflow sequence, hand-written multi-cycle corner
// cases, and a queue-based reference model for randomized traffic.
// ---------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int NV    = 35;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT
  // -------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr_w, mem_addr_r;
  logic [DW-1:0] mem_data_w, mem_data_r;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.addr_size(AW), .word_width(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .mem_we       (mem_we),
    .mem_addr_w   (mem_addr_w),
    .mem_data_w   (mem_data_w),
    .mem_addr_r   (mem_addr_r),
    .mem_data_r   (mem_data_r),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // External memory: synchronous write, asynchronous read.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) if (mem_we) mem[mem_addr_w] <= mem_data_w;
  assign mem_data_r = mem[mem_addr_r];

  // -------------------------------------------------------------------------
  // Scoreboard / reference model
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic          m_ovf, m_udf, m_rv;
  logic [DW-1:0] m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
  endtask

  // FIFO behaviour at one clock edge, judged on occupancy before the edge.
  task automatic model_edge(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    int  sz;
    bit  is_full, is_empty;
    sz       = exp_q.size();
    is_full  = (sz == DEPTH);
    is_empty = (sz == 0);
    m_rv     = r && !is_empty;
    if (m_rv) m_rd = exp_q.pop_front();
    if (w && !is_full) exp_q.push_back(d);
    if (w && is_full) m_ovf = 1'b1;
    else if (c)       m_ovf = 1'b0;
    if (r && is_empty) m_udf = 1'b1;
    else if (c)        m_udf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, "_count"},        count,        sz);
    chk({tag, "_full"},         full,         sz == DEPTH);
    chk({tag, "_empty"},        empty,        sz == 0);
    chk({tag, "_almost_full"},  almost_full,  sz >= AF);
    chk({tag, "_almost_empty"}, almost_empty, sz <= AE);
    chk({tag, "_overflow"},     overflow,     m_ovf);
    chk({tag, "_underflow"},    underflow,    m_udf);
    chk({tag, "_rd_valid"},     rd_valid,     m_rv);
    chk({tag, "_rd_data"},      rd_data,      m_rd);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_count"},        count,        0);
    chk({tag, "_empty"},        empty,        1);
    chk({tag, "_almost_empty"}, almost_empty, 1);
    chk({tag, "_full"},         full,         0);
    chk({tag, "_almost_full"},  almost_full,  0);
    chk({tag, "_rd_valid"},     rd_valid,     0);
    chk({tag, "_rd_data"},      rd_data,      0);
    chk({tag, "_overflow"},     overflow,     0);
    chk({tag, "_underflow"},    underflow,    0);
  endtask

  // -------------------------------------------------------------------------
  // Driver: apply one cycle of requests, check the combinational memory
  // write port, advance one edge, update the model.
  // -------------------------------------------------------------------------
  task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    wr_en   = w;
    rd_en   = r;
    clr_err = c;
    wr_data = d;
    #1;
    chk("mem_we",     mem_we,     w && (exp_q.size() < DEPTH));
    chk("mem_data_w", mem_data_w, d);
    @(posedge clk);
    model_edge(w, r, c, d);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic          wr_en;
    logic          rd_en;
    logic          clr_err;
    logic [DW-1:0] wr_data;
    int            exp_count;
    logic          exp_ovf;
    logic          exp_udf;
    logic          exp_rv;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [0:NV-1];

  function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [DW-1:0] d,
                              input int cnt, input logic ovf, input logic udf,
                              input logic rv, input logic [DW-1:0] rd);
    vec_t v;
    v.wr_en = w; v.rd_en = r; v.clr_err = c; v.wr_data = d;
    v.exp_count = cnt; v.exp_ovf = ovf; v.exp_udf = udf; v.exp_rv = rv; v.exp_rd = rd;
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    model_reset();

    // Fill 0x00..0x0F, push 0xAA while full with a pop, clear, drain 15,
    // then push 0x11 + pop on empty, then pop 0x11.
    for (int i = 0; i < 16; i++) tbl[i] = mk(1, 0, 0, 8'(i), i + 1, 0, 0, 0, 8'h00);
    tbl[16] = mk(1, 1, 0, 8'hAA, 15, 1, 0, 1, 8'h00);
    tbl[17] = mk(0, 0, 1, 8'h00, 15, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 15; k++) tbl[17 + k] = mk(0, 1, 0, 8'h00, 15 - k, 0, 0, 1, 8'(k));
    tbl[33] = mk(1, 1, 0, 8'h11, 1, 0, 1, 0, 8'h0F);
    tbl[34] = mk(0, 1, 0, 8'h00, 0, 0, 1, 1, 8'h11);

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset("reset_init");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string t;
      step(tbl[i].wr_en, tbl[i].rd_en, tbl[i].clr_err, tbl[i].wr_data);
      t = $sformatf("vec%0d", i);
      chk({t, "_count"},        count,        tbl[i].exp_count);
      chk({t, "_full"},         full,         tbl[i].exp_count == DEPTH);
      chk({t, "_empty"},        empty,        tbl[i].exp_count == 0);
      chk({t, "_almost_full"},  almost_full,  tbl[i].exp_count >= AF);
      chk({t, "_almost_empty"}, almost_empty, tbl[i].exp_count <= AE);
      chk({t, "_overflow"},     overflow,     tbl[i].exp_ovf);
      chk({t, "_underflow"},    underflow,    tbl[i].exp_udf);
      chk({t, "_rd_valid"},     rd_valid,     tbl[i].exp_rv);
      chk({t, "_rd_data"},      rd_data,      tbl[i].exp_rd);
    end

    // Steady push+pop at count 5: occupancy and almost flags hold.
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h40 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 8'h50 + 8'(i));
      chk("steady_count", count, 5);
      chk("steady_almost_full", almost_full, 0);
      chk("steady_almost_empty", almost_empty, 0);
      check_model("steady");
    end

    // Reset mid-burst at count 7: outputs return without a clock edge.
    step(1, 0, 0, 8'h60);
    step(1, 0, 0, 8'h61);
    chk("burst_count", count, 7);
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid");
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Sticky flag clear, and error-wins-over-clear in the same cycle.
    step(0, 1, 0, 8'h00);
    check_model("udf_set");
    step(0, 0, 1, 8'h00);
    check_model("udf_clr");
    chk("udf_cleared", underflow, 0);
    step(0, 1, 1, 8'h00);
    check_model("udf_wins");
    chk("udf_wins_set", underflow, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'h80 + 8'(i));
    step(1, 0, 1, 8'hEE);
    check_model("ovf_wins");
    chk("ovf_wins_set", overflow, 1);

    // Randomized traffic in fill / drain / balanced phases.
    for (int p = 0; p < 6; p++) begin
      int pw, pr;
      case (p % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      for (int i = 0; i < 60; i++) begin
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) < 5, 8'($urandom_range(0, 255)));
        check_model($sformatf("rand_p%0d_c%0d", p, i));
      end
    end

    // Drain whatever is left and confirm ordering to the end.
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(0, 1, 0, 8'h00);
      check_model($sformatf("drain%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_fifo_ctrl

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO controller for the team's register-file memory (one synchronous write port, one asynchronous read port). It converts producer push and consumer pop requests into memory write-enable and addresses, keeps wrap-tagged read/write pointers, occupancy and status flags, and registers the read data. It sits between the producer/consumer logic and the memory instance; the memory itself stays outside this block.

## Interface
- addr_size, 4: memory address width; depth = 2**addr_size
- word_width, 8: data word width
- af_level, 2**addr_size-2: almost_full asserts when count >= af_level
- ae_level, 2: almost_empty asserts when count <= ae_level
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  push request
- wr_data  in  word_width  push data
- rd_en  in  1  pop request
- clr_err  in  1  clears sticky error flags
- mem_we  out  1  memory write enable
- mem_addr_w  out  addr_size  memory write address
- mem_data_w  out  word_width  memory write data (wr_data, combinational)
- mem_addr_r  out  addr_size  memory read address
- mem_data_r  in  word_width  memory asynchronous read data
- rd_data  out  word_width  registered pop data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- full, empty, almost_full, almost_empty  out  1 each  status flags
- count  out  addr_size+1  occupancy, 0..2**addr_size
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Pointers wr_ptr, rd_ptr: addr_size+1 bits, binary; MSB is wrap tag; low bits drive mem_addr_w / mem_addr_r.
- empty = (wr_ptr == rd_ptr); full = low bits equal and MSBs differ.
- count = wr_ptr - rd_ptr, modulo 2**(addr_size+1).
- push_ok = wr_en & !full; pop_ok = rd_en & !empty; both use flags of the current cycle.
- mem_we = push_ok (combinational). On push_ok wr_ptr increments at the edge.
- On pop_ok: rd_data <= mem_data_r, rd_ptr increments, rd_valid <= 1; otherwise rd_valid <= 0, rd_data holds.
- wr_en & full: write dropped, overflow sets. This holds even with a simultaneous pop.
- rd_en & empty: no pop, underflow sets. This holds even with a simultaneous push; the push is still accepted.
- Push and pop both accepted in the same cycle: count unchanged, flags unchanged.
- Pointer wrap: increment past 2**(addr_size+1)-1 rolls to 0 with no special case.
- clr_err clears overflow/underflow. A new error event in the same cycle wins (flag stays set).

## Timing
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, rd_valid 0, rd_data 0, overflow 0, underflow 0.
- mem_we and mem_data_w are combinational from wr_en/wr_data/full.
- Pop latency: rd_en sampled at edge N gives rd_data/rd_valid valid after edge N (one cycle).
- Flags and count are registered/derived from pointers and update the cycle after the accepted operation.
- Reset asserted mid-operation aborts all state immediately. Memory contents are not cleared; they are unreachable because the pointers reset.

## Structure
- Shared package constants: depth function (2**addr_size) and pointer width (addr_size+1), for reuse by other FIFO variants.
- One natural sub-module: fifo_ptr (counter with wrap tag, increment enable, asynchronous active-low reset), instantiated twice.
- Flag, count and error logic plus the read register are in the top level.

## Test plan
- Reset, then 16 pushes of 0x00..0x0F (addr_size 4): full=1 after the 16th, count=16, almost_full from count 14, no overflow.
- Push 0xAA while full, with rd_en=1 in the same cycle: overflow=1, 0xAA never read back, pop returns oldest word.
- From empty, push 0x11 and pop the same cycle: underflow=1, count=1; next pop gives rd_data 0x11, rd_valid=1 one cycle later.
- 40 interleaved push/pop operations crossing pointer wrap twice: output order matches input, count never exceeds 16.
- Steady simultaneous push+pop at count 5 for 10 cycles: count stays 5, almost flags stable.
- Assert rst_n low mid-burst at count 7: all outputs reach reset values without a clock edge; clr_err clears sticky flags one cycle later.
